// File: rtl/pipeline_output_fifo.sv
// Elastic valid/ready FIFO placed after single_stage_pipeline; reports occupancy.
// Optional zero-latency empty bypass is enabled with `define PIPE_FIFO_BYPASS_EN.
module pipeline_output_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push, pop, mem_wr, mem_rd, bypass_valid;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;

`ifdef PIPE_FIFO_BYPASS_EN
  assign bypass_valid = empty && in_valid && !rst;
`else
  assign bypass_valid = 1'b0;
`endif

  assign out_valid = (!empty && !rst) || bypass_valid;
  assign pop       = out_valid && out_ready;

  always_comb begin
    out_data = '0;
    if (!empty && !rst) begin
      out_data = mem[rd_ptr_q];
    end else if (bypass_valid) begin
      out_data = in_data;
    end
  end

  // A bypassed beat taken the same cycle never touches storage.
  assign mem_wr = push && !(bypass_valid && out_ready);
  assign mem_rd = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_W'(mem_wr);
    rd_ptr_d = rd_ptr_q + ADDR_W'(mem_rd);
    count_d  = count_q;
    case ({mem_wr, mem_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[wr_ptr_q] <= in_data;
    end
  end
endmodule

// File: tb/tb_pipeline_output_fifo.sv
// Randomized self-checking bench for pipeline_output_fifo against a queue model.
module tb_pipeline_output_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
`ifdef PIPE_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, full, empty;
  logic [DW-1:0] in_data, out_data;
  logic [2:0]    count;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [DW-1:0] q[$];          // model storage
  logic [DW-1:0] got[$];        // beats observed leaving the DUT
  logic [DW-1:0] model_out[$];  // beats the model says should leave

  pipeline_output_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // {in_ready, out_valid, full, empty, count, out_data} predicted from the queue
  function automatic logic [38:0] exp_vec();
    logic byp, ov;
    logic [DW-1:0] od;
    byp = BYP && q.size() == 0 && in_valid && !rst;
    ov  = (q.size() != 0 && !rst) || byp;
    od  = (q.size() != 0 && !rst) ? q[0] : (byp ? in_data : '0);
    return {!rst && q.size() < DEPTH, ov, q.size() == DEPTH, q.size() == 0, 3'(q.size()), od};
  endfunction

  function automatic logic [38:0] dut_vec();
    return {in_ready, out_valid, full, empty, count, out_data};
  endfunction

  task automatic tick(output bit pushed);
    logic byp, ov, popped;
    logic [DW-1:0] od;
    byp    = BYP && q.size() == 0 && in_valid && !rst;
    ov     = (q.size() != 0 && !rst) || byp;
    od     = (q.size() != 0) ? q[0] : in_data;
    pushed = in_valid && !rst && q.size() < DEPTH;
    popped = ov && out_ready;
    if (out_valid === 1'b1 && out_ready) got.push_back(out_data);
    if (popped) model_out.push_back(od);
    if (rst) q.delete();
    else begin
      if (popped && q.size() != 0) void'(q.pop_front());
      if (pushed && !(popped && byp)) q.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit p;
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (dut_vec() !== exp_vec() || in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL reset cyc%0d got %h want %h", i, dut_vec(), exp_vec());
      else pass_cnt++;
      tick(p);
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_stream();
    bit p;
    int idx = 0;
    got.delete(); model_out.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (idx < 5);
      in_data  = 32'hA000_0001 + idx;
      #1;
      total_cnt++;
      if (dut_vec() !== exp_vec() || count > 3'd1) $display("FAIL stream cyc%0d got %h want %h", c, dut_vec(), exp_vec());
      else pass_cnt++;
      tick(p);
      if (p) idx++;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (got.size() != 5) $display("FAIL stream_len got %0d want 5", got.size());
    else pass_cnt++;
    for (int i = 0; i < got.size() && i < 5; i++) begin
      total_cnt++;
      if (got[i] !== 32'hA000_0001 + i) $display("FAIL stream_word%0d got %h want %h", i, got[i], 32'hA000_0001 + i);
      else pass_cnt++;
    end
  endtask

  task automatic test_fill();
    bit p;
    int idx = 0;
    logic [DW-1:0] words [5];
    words = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    got.delete(); model_out.delete();
    out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c == 7) out_ready = 1'b1;
      in_valid = (idx < 5);
      in_data  = words[idx < 5 ? idx : 4];
      #1;
      total_cnt++;
      if (dut_vec() !== exp_vec()) $display("FAIL fill cyc%0d got %h want %h", c, dut_vec(), exp_vec());
      else pass_cnt++;
      if (c == 6) begin
        total_cnt++;
        if (count !== 3'd4 || full !== 1'b1 || in_ready !== 1'b0) $display("FAIL fill_full count=%0d full=%b in_ready=%b want 4/1/0", count, full, in_ready);
        else pass_cnt++;
      end
      tick(p);
      if (p) idx++;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (got.size() != 5) $display("FAIL fill_len got %0d want 5", got.size());
    else pass_cnt++;
    for (int i = 0; i < got.size() && i < 5; i++) begin
      total_cnt++;
      if (got[i] !== words[i]) $display("FAIL fill_word%0d got %h want %h", i, got[i], words[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    bit p;
    got.delete(); model_out.delete();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_data = $urandom;
      #1;
      tick(p);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data = $urandom;
      #1;
      total_cnt++;
      if (dut_vec() !== exp_vec() || count !== 3'd2) $display("FAIL wrap cyc%0d got %h want %h", c, dut_vec(), exp_vec());
      else pass_cnt++;
      tick(p);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin #1; tick(p); end
    total_cnt++;
    if (got.size() != 12 || got != model_out) $display("FAIL wrap_seq got %0d beats want %0d matching", got.size(), model_out.size());
    else pass_cnt++;
  endtask

  task automatic test_random();
    bit p, hold;
    int sent = 0;
    logic [DW-1:0] prev;
    got.delete(); model_out.delete();
    hold = 1'b0; prev = '0;
    for (int c = 0; c < 60 && (sent < 10 || q.size() != 0); c++) begin
      out_ready = (c >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
      in_valid  = (sent < 10) && ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      #1;
      total_cnt++;
      if (dut_vec() !== exp_vec()) $display("FAIL random cyc%0d got %h want %h", c, dut_vec(), exp_vec());
      else pass_cnt++;
      if (hold) begin
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== prev) $display("FAIL stable cyc%0d got %b/%h want 1/%h", c, out_valid, out_data, prev);
        else pass_cnt++;
      end
      hold = out_valid && !out_ready;
      prev = out_data;
      tick(p);
      if (p) sent++;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (got.size() != 10 || got != model_out) $display("FAIL random_seq got %0d beats want 10 matching", got.size());
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    bit p;
    logic [DW-1:0] fresh [2];
    fresh = '{32'hC0DE_0001, 32'hC0DE_0002};
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = 32'hBAD0_0000 + c;
      #1;
      tick(p);
    end
    total_cnt++;
    if (count !== 3'd3) $display("FAIL pre_reset_count got %0d want 3", count);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    tick(p);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    total_cnt++;
    if (dut_vec() !== exp_vec() || count !== 3'd0 || out_valid !== 1'b0) $display("FAIL mid_reset got %h want %h", dut_vec(), exp_vec());
    else pass_cnt++;
    got.delete(); model_out.delete();
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 2);
      in_data  = fresh[c < 2 ? c : 1];
      #1;
      tick(p);
    end
    in_valid = 1'b0;
    total_cnt++;
    if (got.size() != 2 || got[0] !== fresh[0] || got[1] !== fresh[1]) $display("FAIL post_reset_seq got %0d beats first %h want 2 beats %h", got.size(), (got.size() > 0) ? got[0] : '0, fresh[0]);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_fill();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
